// File: rtl/step_sequencer_if.sv
// Move-command channel into the step sequencer: valid/ready handshake plus move fields.
interface step_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [PER_W-1:0] cmd_period;
  logic [PER_W-1:0] cmd_start_period;
  logic [PER_W-1:0] cmd_accel;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_start_period, cmd_accel,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_start_period, cmd_accel,
    output cmd_ready
  );
endinterface

// File: rtl/step_sequencer.sv
// Step/dir pulse-train generator with symmetric linear-period trapezoid ramp,
// absolute position tracking and abort at pulse boundaries.
module step_sequencer #(
  parameter int CNT_W     = 16,
  parameter int PER_W     = 16,
  parameter int POS_W     = 24,
  parameter int PULSE_W   = 4,
  parameter int DIR_SETUP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  step_sequencer_if.slave  cmd,
  input  logic             abort,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_left,
  output logic [POS_W-1:0] position
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [PER_W-1:0] MIN_PER    = PER_W'(2 * PULSE_W);
  localparam logic [PER_W-1:0] HI_LOAD    = PER_W'(PULSE_W - 1);
  localparam logic [PER_W-1:0] SETUP_LOAD = PER_W'(DIR_SETUP - 1);
  localparam logic [PER_W-1:0] PULSE_LEN  = PER_W'(PULSE_W);

  state_t           state_r;
  logic [PER_W-1:0] tmr_r;
  logic [PER_W-1:0] lo_len_r;
  logic [PER_W-1:0] cur_period_r;
  logic [PER_W-1:0] period_r;
  logic [PER_W-1:0] start_eff_r;
  logic [PER_W-1:0] accel_r;
  logic [CNT_W-1:0] ramp_cnt_r;

  logic [CNT_W-1:0] sl_dec_s;
  logic [PER_W-1:0] eff_s;
  logic [PER_W-1:0] cur_next_s;
  logic [CNT_W-1:0] ramp_next_s;
  logic [PER_W:0]   sum_s;
  logic [PER_W:0]   floor_s;
  logic [PER_W-1:0] start_eff_s;
  logic [POS_W-1:0] pos_delta_s;
  logic             enter_hi_s;

  assign start_eff_s = (cmd.cmd_start_period < cmd.cmd_period) ? cmd.cmd_period
                                                                : cmd.cmd_start_period;
  assign pos_delta_s = dir ? POS_W'(1) : {POS_W{1'b1}};

  // Ramp step: decelerate once remaining steps fit in the ramp already climbed, else accelerate.
  always_comb begin
    sl_dec_s    = steps_left - CNT_W'(1);
    eff_s       = (cur_period_r < MIN_PER) ? MIN_PER : cur_period_r;
    sum_s       = {1'b0, cur_period_r} + {1'b0, accel_r};
    floor_s     = {1'b0, period_r} + {1'b0, accel_r};
    cur_next_s  = cur_period_r;
    ramp_next_s = ramp_cnt_r;
    if (sl_dec_s <= ramp_cnt_r) begin
      if (sum_s > {1'b0, start_eff_r}) begin
        cur_next_s = start_eff_r;
      end else begin
        cur_next_s = sum_s[PER_W-1:0];
      end
    end else if (cur_period_r > period_r) begin
      if ({1'b0, cur_period_r} >= floor_s) begin
        cur_next_s = cur_period_r - accel_r;
      end else begin
        cur_next_s = period_r;
      end
      ramp_next_s = ramp_cnt_r + CNT_W'(1);
    end else begin
      cur_next_s  = cur_period_r;
      ramp_next_s = ramp_cnt_r;
    end
  end

  // Start of a new step pulse, from the end of setup or the end of a low phase.
  always_comb begin
    enter_hi_s = 1'b0;
    case (state_r)
      S_SETUP: enter_hi_s = (tmr_r == PER_W'(0)) && !abort;
      S_LO:    enter_hi_s = (tmr_r == PER_W'(0)) && !abort && (steps_left != CNT_W'(0));
      default: enter_hi_s = 1'b0;
    endcase
  end

  // Move FSM with registered outputs; pulse-entry bookkeeping applied after the case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      tmr_r         <= PER_W'(0);
      lo_len_r      <= PER_W'(0);
      cur_period_r  <= PER_W'(0);
      period_r      <= PER_W'(0);
      start_eff_r   <= PER_W'(0);
      accel_r       <= PER_W'(0);
      ramp_cnt_r    <= CNT_W'(0);
      step          <= 1'b0;
      dir           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      steps_left    <= CNT_W'(0);
      position      <= POS_W'(0);
      cmd.cmd_ready <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            dir           <= cmd.cmd_dir;
            busy          <= 1'b1;
            steps_left    <= cmd.cmd_steps;
            period_r      <= cmd.cmd_period;
            start_eff_r   <= start_eff_s;
            accel_r       <= cmd.cmd_accel;
            cur_period_r  <= start_eff_s;
            ramp_cnt_r    <= CNT_W'(0);
            tmr_r         <= SETUP_LOAD;
            aborted       <= 1'b0;
            cmd.cmd_ready <= 1'b0;
            if (cmd.cmd_steps == CNT_W'(0)) begin
              state_r <= S_FIN;
              done    <= 1'b1;
            end else begin
              state_r <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (abort) begin
            state_r <= S_FIN;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (tmr_r != PER_W'(0)) begin
            tmr_r <= tmr_r - PER_W'(1);
          end
        end
        S_HI: begin
          if (tmr_r == PER_W'(0)) begin
            step    <= 1'b0;
            tmr_r   <= lo_len_r - PER_W'(1);
            state_r <= S_LO;
          end else begin
            tmr_r <= tmr_r - PER_W'(1);
          end
        end
        S_LO: begin
          if (tmr_r != PER_W'(0)) begin
            tmr_r <= tmr_r - PER_W'(1);
          end else if (!enter_hi_s) begin
            state_r <= S_FIN;
            done    <= 1'b1;
            aborted <= (steps_left != CNT_W'(0));
          end
        end
        S_FIN: begin
          done          <= 1'b0;
          aborted       <= 1'b0;
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
          state_r       <= S_IDLE;
        end
        default: begin
          state_r       <= S_IDLE;
          step          <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
        end
      endcase

      // The period timed from this rise uses the pre-update cur_period.
      if (enter_hi_s) begin
        state_r      <= S_HI;
        step         <= 1'b1;
        tmr_r        <= HI_LOAD;
        lo_len_r     <= eff_s - PULSE_LEN;
        position     <= position + pos_delta_s;
        steps_left   <= sl_dec_s;
        cur_period_r <= cur_next_s;
        ramp_cnt_r   <= ramp_next_s;
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Randomized bench for step_sequencer: each move is predicted as a timeline of rise
// cycles, done cycle and final counters, then compared with the observed pulse train.
module tb_step_sequencer;
  localparam int CNT_W     = 16;
  localparam int PER_W     = 16;
  localparam int POS_W     = 24;
  localparam int PULSE_W   = 4;
  localparam int DIR_SETUP = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             abort = 1'b0;
  logic             step, dir, busy, done, aborted;
  logic [CNT_W-1:0] steps_left;
  logic [POS_W-1:0] position;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  longint model_pos = 0;

  step_sequencer_if #(.CNT_W(CNT_W), .PER_W(PER_W)) cmd_bus ();

  step_sequencer #(
    .CNT_W(CNT_W), .PER_W(PER_W), .POS_W(POS_W), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_bus.slave), .abort(abort),
    .step(step), .dir(dir), .busy(busy), .done(done), .aborted(aborted),
    .steps_left(steps_left), .position(position)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ab_off = 0: no abort; otherwise abort is raised (and held) at accept cycle + ab_off.
  task automatic run_move(input logic d, input int steps, input int per, input int st,
                          input int acc, input int ab_off);
    int T, A, t, eff, cur, ramp, sl, se, exp_done, w, busy_cnt, hi_len, obs_done, nr;
    bit exp_ab, seen_done, prev_step, obs_ab, obs_dir;
    longint obs_sl, obs_pos;
    int exp_rise[$];
    int rises[$];
    int highs[$];

    @(negedge clk);
    cmd_bus.cmd_dir          = d;
    cmd_bus.cmd_steps        = CNT_W'(steps);
    cmd_bus.cmd_period       = PER_W'(per);
    cmd_bus.cmd_start_period = PER_W'(st);
    cmd_bus.cmd_accel        = PER_W'(acc);
    cmd_bus.cmd_valid        = 1'b1;
    w = 0;
    while (!cmd_bus.cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_val("accept_ready", cmd_bus.cmd_ready, 1);
    T = cyc;

    // Expected timeline from the ramp rules.
    A = (ab_off > 0) ? T + ab_off : 32'h3fffffff;
    se = (st < per) ? per : st;
    cur = se; ramp = 0; sl = steps; exp_ab = 1'b0; exp_done = 0;
    if (steps == 0) begin
      exp_done = T + 1;
    end else if (A <= T + 2) begin
      exp_done = ((A > T + 1) ? A : T + 1) + 1;
      exp_ab = 1'b1;
    end else begin
      t = T + 1 + DIR_SETUP;
      for (int i = 0; i < steps; i++) begin
        exp_rise.push_back(t);
        eff = (cur < 2 * PULSE_W) ? 2 * PULSE_W : cur;
        sl--;
        model_pos += d ? 1 : -1;
        if (sl <= ramp) begin
          cur = (cur + acc > se) ? se : cur + acc;
        end else if (cur > per) begin
          cur = (cur - acc < per) ? per : cur - acc;
          ramp++;
        end
        if (sl == 0) begin
          exp_done = t + eff;
          break;
        end
        if (A <= t + eff - 1) begin
          exp_done = t + eff;
          exp_ab = 1'b1;
          break;
        end
        t += eff;
      end
    end

    prev_step = 1'b0; hi_len = 0; busy_cnt = 0; seen_done = 1'b0;
    obs_done = 0; obs_ab = 1'b0; obs_sl = 0; obs_pos = 0; obs_dir = 1'b0;
    for (int c = 0; c < 20000 && !seen_done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        // Keep offering a different command while busy; it must be ignored.
        cmd_bus.cmd_dir   = ~d;
        cmd_bus.cmd_steps = CNT_W'($urandom_range(1, 50));
        cmd_bus.cmd_period = PER_W'($urandom_range(1, 20));
      end
      if (step && !prev_step) rises.push_back(cyc);
      if (step) hi_len++;
      else if (prev_step) begin
        highs.push_back(hi_len);
        hi_len = 0;
      end
      prev_step = step;
      if (busy) busy_cnt++;
      if (done) begin
        seen_done = 1'b1;
        obs_done = cyc; obs_ab = aborted; obs_sl = steps_left;
        obs_pos = position; obs_dir = dir;
        cmd_bus.cmd_valid = 1'b0;
      end else if (cyc == A) begin
        abort = 1'b1;
      end
    end

    check_val("done_seen", seen_done, 1);
    check_val("done_cycle", obs_done - T, exp_done - T);
    check_val("aborted", obs_ab, exp_ab);
    check_val("steps_left", obs_sl, sl);
    check_val("position", obs_pos, model_pos & 64'hFFFFFF);
    check_val("dir", obs_dir, d);
    check_val("busy_cycles", busy_cnt, exp_done - T);
    check_val("rise_count", rises.size(), exp_rise.size());
    nr = (rises.size() < exp_rise.size()) ? rises.size() : exp_rise.size();
    for (int i = 0; i < nr; i++) check_val("rise_cycle", rises[i] - T, exp_rise[i] - T);
    for (int i = 0; i < highs.size(); i++) check_val("high_width", highs[i], PULSE_W);
    abort = 1'b0;
    @(negedge clk);
    check_val("done_pulse_end", done, 0);
    check_val("busy_after", busy, 0);
    check_val("ready_after", cmd_bus.cmd_ready, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_step"}, step, 0);
    check_val({tag, "_dir"}, dir, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_aborted"}, aborted, 0);
    check_val({tag, "_ready"}, cmd_bus.cmd_ready, 1);
    check_val({tag, "_steps_left"}, steps_left, 0);
    check_val({tag, "_position"}, position, 0);
  endtask

  initial begin
    int w;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_dir = 1'b0;
    cmd_bus.cmd_steps = CNT_W'(0);
    cmd_bus.cmd_period = PER_W'(0);
    cmd_bus.cmd_start_period = PER_W'(0);
    cmd_bus.cmd_accel = PER_W'(0);
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    run_move(1'b1, 4, 10, 10, 0, 0);     // constant rate
    run_move(1'b1, 6, 10, 20, 5, 0);     // trapezoid 20,15,10,10,15,20
    run_move(1'b1, 0, 10, 10, 0, 0);     // null move
    run_move(1'b0, 100, 10, 10, 0, 24);  // abort during third high pulse
    run_move(1'b1, 5, 3, 3, 0, 0);       // period clamped to 2*PULSE_W
    run_move(1'b1, 5, 10, 10, 0, 1);     // abort during setup
    run_move(1'b0, 3, 12, 5, 2, 0);      // start below cruise period

    // Async reset while the step output is high.
    @(negedge clk);
    cmd_bus.cmd_dir = 1'b1;
    cmd_bus.cmd_steps = CNT_W'(50);
    cmd_bus.cmd_period = PER_W'(10);
    cmd_bus.cmd_start_period = PER_W'(10);
    cmd_bus.cmd_accel = PER_W'(0);
    cmd_bus.cmd_valid = 1'b1;
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    w = 0;
    while (!step && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_val("mid_move_step_high", step, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_reset");
    model_pos = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_move(1'b1, 3, 12, 12, 0, 0);

    for (int k = 0; k < 25; k++) begin
      run_move(1'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
               int'($urandom_range(1, 30)), int'($urandom_range(1, 40)),
               int'($urandom_range(0, 8)),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 80)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
